vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive side of the 320x240 VGA timing interface. Samples incoming active-low hsync/vsync, measures line and
//  frame lengths, qualifies lock, and regenerates pixel_x/pixel_y/de for capture, loopback check and downstream
//  consumers of an external or looped-back VGA stream. One clock domain; sync inputs are already in that domain.
// PARAMETERS
//  H_ACTIVE 320 active pixels/line;   H_FRONT 8;   H_SYNC 96;   H_BACK 40;   H_TOTAL = sum (464)
//  V_ACTIVE 240 active lines/frame;   V_FRONT 2;   V_SYNC 2;    V_BACK 25;   V_TOTAL = sum (269)
//  ERR_LIMIT 3 consecutive bad lines/frames in LOCKED before dropping to HUNT
// PORTS
//  clk           in   1   pixel clock
//  reset         in   1   synchronous, active-high
//  hsync_in      in   1   horizontal sync, active low
//  vsync_in      in   1   vertical sync, active low
//  pixel_x       out  10  active column 0..H_ACTIVE-1; 0 outside active
//  pixel_y       out  10  active row 0..V_ACTIVE-1; 0 outside active
//  de            out  1   high only when locked and inside active area
//  locked        out  1   timing qualified
//  frame_start   out  1   one-cycle pulse at every frame boundary (any state)
//  sync_err      out  1   one-cycle pulse on LOCKED->HUNT
//  h_total_meas  out  10  last measured line length in clocks
//  v_total_meas  out  10  last measured frame length in lines
// BEHAVIOUR
//  Reset: all outputs 0; h_pos=v_pos=0; err_cnt=0; line_bad=0; vs_pend=0; input flops=1 (idle); state HUNT.
//  Input: hs_q<=hsync_in, hs_q2<=hs_q; h_fall = hs_q2 & ~hs_q (same for vsync -> v_fall). Pin fall -> h_pos=0 is 2 clks.
//  h_pos: <=0 on h_fall, else +1 saturating at 1023. On h_fall: h_total_meas<=h_pos+1; line good iff h_pos+1==H_TOTAL.
//  v_fall sets vs_pend. On h_fall: if vs_pend -> frame boundary: v_pos<=0, vs_pend<=0, frame_start pulses,
//   v_total_meas<=v_pos+1; else v_pos<=v_pos+1, saturating at 1023. v_fall and h_fall in same cycle: boundary taken now.
//  Frame good iff v_total_meas==V_TOTAL and no bad line since previous boundary (line_bad flag, cleared at boundary).
//  Coordinates: hx = h_pos-(H_SYNC+H_BACK); vy = v_pos-(V_SYNC+V_BACK-1) (line after sync-start carries row 0).
//   Active iff 0<=hx<H_ACTIVE and 0<=vy<V_ACTIVE; then pixel_x<=hx, pixel_y<=vy, de<=locked; else all 0. Registered, 1 clk.
//  FSM:
//   HUNT:   outputs de=0, locked=0; first frame boundary -> TRACK.
//   TRACK:  any bad line -> HUNT; frame boundary with good frame -> LOCKED (locked=1 next clk); bad frame -> HUNT.
//   LOCKED: bad line or bad frame: err_cnt+1; good line clears err_cnt. err_cnt reaching ERR_LIMIT -> HUNT,
//           sync_err pulse, locked=0 and de=0 next clk, err_cnt=0. Missing hsync: h_pos saturates, no h_fall, so
//           watchdog: h_pos==1023 counts as bad line once (then held until next h_fall).
//  Arithmetic: 10-bit unsigned; subtractions done in 11 bits, sign bit = outside active.
//  Reset asserted mid-frame: immediate return to reset state next clk; relock needs one full good frame again.
// TESTING
//  Nominal 464x269 stream from timing-generator model -> locked rises 1 clk after 2nd frame boundary;
//   per locked frame de count=76800, pixel_x 0..319, pixel_y 0..239; h_total_meas=464, v_total_meas=269.
//  One 463-clk line while LOCKED -> err_cnt=1, locked stays 1; next good line clears err_cnt to 0.
//  Three consecutive 463-clk lines -> sync_err single pulse, locked=0, de=0 next clk, state HUNT.
//  Frame of 270 lines in TRACK -> back to HUNT, locked never asserts; v_total_meas=270.
//  hsync_in held high 2000 clks while LOCKED -> h_pos saturates 1023, err_cnt+1, no further errors while stuck.
//  reset pulsed mid-frame at pixel (100,50) -> all outputs 0 next clk; relock after two more frame boundaries.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery.
// Measures line/frame lengths, qualifies lock, regenerates x/y/de.
module vga_sync_decoder #(
    parameter int H_ACTIVE  = 320,
    parameter int H_FRONT   = 8,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 40,
    parameter int V_ACTIVE  = 240,
    parameter int V_FRONT   = 2,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 25,
    parameter int ERR_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int ERR_W   = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT);

    localparam logic [9:0]  H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [10:0] H_OFS   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] V_OFS   = 11'(V_SYNC + V_BACK - 1);
    localparam logic [9:0]  POS_MAX = 10'h3ff;
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             hs_q, hs_q2, vs_q, vs_q2;
    logic [9:0]       h_pos_q, h_pos_d;
    logic [9:0]       v_pos_q, v_pos_d;
    logic [9:0]       h_meas_q, h_meas_d;
    logic [9:0]       v_meas_q, v_meas_d;
    logic             vs_pend_q, vs_pend_d;
    logic             line_bad_q, line_bad_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [9:0]       px_q, px_d;
    logic [9:0]       py_q, py_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic             serr_q, serr_d;

    logic       h_fall, v_fall, boundary;
    logic [9:0] h_len, v_len;
    logic       line_good, line_bad_evt, frame_bad;
    logic [10:0] hx, vy;
    logic       active;

    // Edge detect and line/frame measurement.
    always_comb begin
        h_fall       = hs_q2 & ~hs_q;
        v_fall       = vs_q2 & ~vs_q;
        boundary     = h_fall & (vs_pend_q | v_fall);
        h_len        = (h_pos_q == POS_MAX) ? POS_MAX : h_pos_q + 10'd1;
        v_len        = (v_pos_q == POS_MAX) ? POS_MAX : v_pos_q + 10'd1;
        line_good    = h_fall & (h_len == H_TOT);
        // A stuck hsync counts once, on the way into saturation.
        line_bad_evt = (h_fall & (h_len != H_TOT))
                     | (~h_fall & (h_pos_q == POS_MAX - 10'd1));
        frame_bad    = boundary & ((v_len != V_TOT) | line_bad_q | line_bad_evt);

        h_pos_d    = h_fall ? 10'd0
                   : ((h_pos_q == POS_MAX) ? h_pos_q : h_pos_q + 10'd1);
        h_meas_d   = h_fall ? h_len : h_meas_q;
        v_pos_d    = v_pos_q;
        if (boundary)
            v_pos_d = 10'd0;
        else if (h_fall && v_pos_q != POS_MAX)
            v_pos_d = v_pos_q + 10'd1;
        v_meas_d   = boundary ? v_len : v_meas_q;
        vs_pend_d  = boundary ? 1'b0 : (vs_pend_q | v_fall);
        line_bad_d = boundary ? 1'b0 : (line_bad_q | line_bad_evt);
        fs_d       = boundary;
    end

    // Lock qualification state machine.
    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        serr_d    = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (boundary)
                    state_d = TRACK;
            end
            TRACK: begin
                if (line_bad_evt || frame_bad)
                    state_d = HUNT;
                else if (boundary)
                    state_d = LOCKED;
            end
            LOCKED: begin
                if (line_bad_evt || frame_bad) begin
                    if (err_cnt_q == ERR_LAST) begin
                        state_d   = HUNT;
                        err_cnt_d = '0;
                        serr_d    = 1'b1;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else if (line_good) begin
                    err_cnt_d = '0;
                end
            end
            default: begin
                state_d   = HUNT;
                err_cnt_d = '0;
            end
        endcase
    end

    // Active-area coordinates; 11-bit difference, sign bit = outside.
    always_comb begin
        hx     = {1'b0, h_pos_q} - H_OFS;
        vy     = {1'b0, v_pos_q} - V_OFS;
        active = ~hx[10] && (hx[9:0] < H_ACT)
              && ~vy[10] && (vy[9:0] < V_ACT);
        px_d   = active ? hx[9:0] : 10'd0;
        py_d   = active ? vy[9:0] : 10'd0;
        de_d   = active && (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q       <= 1'b1;
            hs_q2      <= 1'b1;
            vs_q       <= 1'b1;
            vs_q2      <= 1'b1;
            state_q    <= HUNT;
            h_pos_q    <= '0;
            v_pos_q    <= '0;
            h_meas_q   <= '0;
            v_meas_q   <= '0;
            vs_pend_q  <= 1'b0;
            line_bad_q <= 1'b0;
            err_cnt_q  <= '0;
            px_q       <= '0;
            py_q       <= '0;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            hs_q       <= hsync_in;
            hs_q2      <= hs_q;
            vs_q       <= vsync_in;
            vs_q2      <= vs_q;
            state_q    <= state_d;
            h_pos_q    <= h_pos_d;
            v_pos_q    <= v_pos_d;
            h_meas_q   <= h_meas_d;
            v_meas_q   <= v_meas_d;
            vs_pend_q  <= vs_pend_d;
            line_bad_q <= line_bad_d;
            err_cnt_q  <= err_cnt_d;
            px_q       <= px_d;
            py_q       <= py_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            serr_q     <= serr_d;
        end
    end

    assign pixel_x      = px_q;
    assign pixel_y      = py_q;
    assign de           = de_q;
    assign locked       = (state_q == LOCKED);
    assign frame_start  = fs_q;
    assign sync_err     = serr_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: frame-level table plus randomized stream,
// checked every cycle against an event-level reference model.
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB - 1;
    localparam int ELIM = 3;

    logic       clk = 1'b0;
    logic       reset, hsync_in, vsync_in;
    logic [9:0] pixel_x, pixel_y, h_total_meas, v_total_meas;
    logic       de, locked, frame_start, sync_err;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .ERR_LIMIT(ELIM)
    ) dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .de(de), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // reference model: timestamps of decoded events, line/frame rules
    int cyc, t_h, nl, st, err, hmeas, vmeas;
    bit pend, lbad, ph0, ph1, pv0, pv1;
    int e_px, e_py;
    bit e_de, e_lk, e_fs, e_se;
    int cnt_de, cnt_fs, cnt_se;

    typedef struct {
        int nl; int bidx; int bcnt; int blen;
        bit lk; int se; int fs; int vt; int de;
    } row_t;
    row_t rows[13];

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_step(input bit r, input bit hin, input bit vin);
        int hp, vp, len, hx, vy;
        bit hf, vf, lb, lg, fb, fgood, se, act;
        cyc++;
        if (r) begin
            t_h = cyc; nl = 0; pend = 0; lbad = 0; st = 0; err = 0;
            ph0 = 1; ph1 = 1; pv0 = 1; pv1 = 1; hmeas = 0; vmeas = 0;
            e_px = 0; e_py = 0; e_de = 0; e_lk = 0; e_fs = 0; e_se = 0;
            return;
        end
        hp = mn(cyc - 1 - t_h, 1023);
        vp = mn(nl, 1023);
        hf = ph1 && !ph0;
        vf = pv1 && !pv0;
        lb = 0; lg = 0; fb = 0; fgood = 0; se = 0;
        if (hf) begin
            len = cyc - t_h;
            hmeas = mn(len, 1023);
            lg = (len == HT);
            lb = !lg;
            t_h = cyc;
            fb = pend || vf;
        end else if (cyc - t_h == 1023) begin
            lb = 1;
        end
        if (fb) begin
            vmeas = mn(nl + 1, 1023);
            fgood = (vmeas == VT) && !lbad && !lb;
            nl = 0; pend = 0; lbad = 0;
        end else begin
            if (hf) nl++;
            if (vf) pend = 1;
            lbad = lbad | lb;
        end
        case (st)
            0: if (fb) st = 1;
            1: if (lb || (fb && !fgood)) st = 0;
               else if (fb) st = 2;
            default: begin
                if (lb || (fb && !fgood)) begin
                    err++;
                    if (err >= ELIM) begin st = 0; err = 0; se = 1; end
                end else if (lg) err = 0;
            end
        endcase
        hx = hp - HOFF;
        vy = vp - VOFF;
        act = hx >= 0 && hx < HA && vy >= 0 && vy < VA;
        e_px = act ? hx : 0;
        e_py = act ? vy : 0;
        e_lk = (st == 2);
        e_de = act && e_lk;
        e_fs = fb;
        e_se = se;
        ph1 = ph0; ph0 = hin;
        pv1 = pv0; pv0 = vin;
    endtask

    task automatic tick(input bit h, input bit v, input bit r);
        logic [43:0] got, exp;
        @(negedge clk);
        hsync_in = h; vsync_in = v; reset = r;
        @(posedge clk);
        #1;
        model_step(r, h, v);
        got = {pixel_x, pixel_y, de, locked, frame_start, sync_err,
               h_total_meas, v_total_meas};
        exp = {10'(e_px), 10'(e_py), e_de, e_lk, e_fs, e_se,
               10'(hmeas), 10'(vmeas)};
        chk("cycle", longint'(got), longint'(exp));
        cnt_de += int'(de);
        cnt_fs += int'(frame_start);
        cnt_se += int'(sync_err);
    endtask

    function automatic bit vlvl(input int l, input int i, input int vo);
        return !((l == 0 && i >= vo) || (l == 1) || (l == 2 && i < vo));
    endfunction

    task automatic gen_frame(input int n, input int bi, input int bc,
                             input int bl, input int vo);
        int len;
        for (int l = 0; l < n; l++) begin
            len = (bi >= 0 && l >= bi && l < bi + bc) ? bl : HT;
            for (int i = 0; i < len; i++)
                tick(i >= HS, vlvl(l, i, vo), 1'b0);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            cnt_de = 0; cnt_fs = 0; cnt_se = 0;
            gen_frame(rows[r].nl, rows[r].bidx, rows[r].bcnt,
                      rows[r].blen, 0);
            chk($sformatf("row%0d locked", r), locked, rows[r].lk);
            chk($sformatf("row%0d sync_err", r), cnt_se, rows[r].se);
            chk($sformatf("row%0d frame_start", r), cnt_fs, rows[r].fs);
            chk($sformatf("row%0d v_total", r), v_total_meas, rows[r].vt);
            chk($sformatf("row%0d de_count", r), cnt_de, rows[r].de);
        end
    endtask

    int rnl, rvo, rlen;

    initial begin
        reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        cyc = 0;
        rows[0]  = '{VT,     -1, 0, HT,     1'b0, 0, 1, 1,  0};
        rows[1]  = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};
        rows[2]  = '{VT,      5, 1, HT - 1, 1'b1, 0, 1, VT, HA*VA};
        rows[3]  = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};
        rows[4]  = '{VT,      5, 3, HT - 1, 1'b0, 1, 1, VT, HA*4};
        rows[5]  = '{VT + 1, -1, 0, HT,     1'b0, 0, 1, VT, 0};
        rows[6]  = '{VT,     -1, 0, HT,     1'b0, 0, 1, VT + 1, 0};
        rows[7]  = '{VT,     -1, 0, HT,     1'b0, 0, 1, VT, 0};
        rows[8]  = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};
        rows[9]  = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};
        rows[10] = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};
        rows[11] = '{VT,     -1, 0, HT,     1'b0, 0, 1, 1,  0};
        rows[12] = '{VT,     -1, 0, HT,     1'b1, 0, 1, VT, HA*VA};

        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("reset outputs",
            {pixel_x, pixel_y, de, locked, frame_start, sync_err,
             h_total_meas, v_total_meas}, 0);

        run_rows(0, 8);

        // hsync stuck high while locked: one watchdog error only
        cnt_de = 0; cnt_fs = 0; cnt_se = 0;
        repeat (2000) tick(1'b1, 1'b1, 1'b0);
        chk("stuck locked", locked, 1);
        chk("stuck sync_err", cnt_se, 0);
        chk("stuck frame_start", cnt_fs, 0);
        chk("stuck de_count", cnt_de, 0);

        run_rows(9, 10);

        // reset mid-frame at an active pixel
        for (int l = 0; l < 7; l++)
            for (int i = 0; i < HT; i++)
                tick(i >= HS, vlvl(l, i, 0), 1'b0);
        for (int i = 0; i < 20; i++)
            tick(i >= HS, 1'b1, 1'b0);
        chk("pre-reset pixel_x", pixel_x, 5);
        chk("pre-reset pixel_y", pixel_y, 3);
        chk("pre-reset de", de, 1);
        tick(1'b1, 1'b1, 1'b1);
        chk("mid reset outputs",
            {pixel_x, pixel_y, de, locked, frame_start, sync_err,
             h_total_meas, v_total_meas}, 0);

        run_rows(11, 12);

        // randomized stream against the reference model
        for (int f = 0; f < 30; f++) begin
            rnl = ($urandom_range(0, 5) == 0)
                ? (($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1) : VT;
            rvo = ($urandom_range(0, 7) == 0) ? $urandom_range(1, HT - 1) : 0;
            for (int l = 0; l < rnl; l++) begin
                rlen = ($urandom_range(0, 39) == 0)
                     ? (($urandom_range(0, 1) == 0) ? HT - 1 : HT + 3) : HT;
                for (int i = 0; i < rlen; i++)
                    tick(i >= HS, vlvl(l, i, rvo), 1'b0);
            end
            if ($urandom_range(0, 11) == 0)
                repeat (1100) tick(1'b1, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
